// File: rtl/srff_pkg.sv
// rtl/srff_pkg.sv - shared encodings and next-state function for the SR flip-flop bank
package srff_pkg;

    localparam int SR_HOLD   = 0;
    localparam int SR_SET    = 1;
    localparam int SR_CLR    = 2;
    localparam int SR_TOGGLE = 3;

    // S=R=1 resolves through policy, so q never goes X for any legal input
    function automatic logic sr_next(input logic s, input logic r, input logic q, input int policy);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (policy)
                    SR_SET:    nxt = 1'b1;
                    SR_CLR:    nxt = 1'b0;
                    SR_TOGGLE: nxt = ~q;
                    default:   nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/srff_if.sv
// rtl/srff_if.sv - signal bundle for driving and observing an srff bank
interface srff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] invalid;

    modport master (output s, output r, input q, input qn, input invalid);
    modport slave  (input s, input r, output q, output qn, output invalid);
endinterface

// File: rtl/srff_bit.sv
// rtl/srff_bit.sv - single SR storage cell with registered S=R=1 flag
module srff_bit
    import srff_pkg::*;
#(
    parameter int   BOTH_POLICY = SR_HOLD,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_invalid
);

    logic r_q;
    logic r_invalid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q       <= RESET_VAL;
            r_invalid <= 1'b0;
        end else begin
            r_q       <= sr_next(i_s, i_r, r_q, BOTH_POLICY);
            r_invalid <= i_s & i_r;
        end
    end

    assign o_q       = r_q;
    assign o_invalid = r_invalid;

endmodule

// File: rtl/srff.sv
// rtl/srff.sv - WIDTH-bit bank of independent clocked SR flip-flops
module srff
    import srff_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               BOTH_POLICY = SR_HOLD,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] invalid
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_invalid;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        srff_bit #(
            .BOTH_POLICY (BOTH_POLICY),
            .RESET_VAL   (RESET_VAL[g])
        ) u_bit (
            .i_clk     (clk),
            .i_rst     (reset),
            .i_s       (s[g]),
            .i_r       (r[g]),
            .o_q       (w_q[g]),
            .o_invalid (w_invalid[g])
        );
    end

    assign q       = w_q;
    assign qn      = ~w_q;
    assign invalid = w_invalid;

endmodule

// File: tb/tb_srff.sv
// tb/tb_srff.sv - table-driven check of srff across all S=R=1 policies and a 4-bit bank
module tb_srff;
    import srff_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #50 clk = ~clk;

    srff_if #(.WIDTH(1)) if_p0 ();
    srff_if #(.WIDTH(1)) if_p1 ();
    srff_if #(.WIDTH(1)) if_p2 ();
    srff_if #(.WIDTH(1)) if_p3 ();
    srff_if #(.WIDTH(4)) if_w4 ();

    srff #(.WIDTH(1), .BOTH_POLICY(SR_HOLD), .RESET_VAL(1'b0)) u_p0 (
        .s(if_p0.s), .r(if_p0.r), .clk(clk), .reset(reset),
        .q(if_p0.q), .qn(if_p0.qn), .invalid(if_p0.invalid));
    srff #(.WIDTH(1), .BOTH_POLICY(SR_SET), .RESET_VAL(1'b0)) u_p1 (
        .s(if_p1.s), .r(if_p1.r), .clk(clk), .reset(reset),
        .q(if_p1.q), .qn(if_p1.qn), .invalid(if_p1.invalid));
    srff #(.WIDTH(1), .BOTH_POLICY(SR_CLR), .RESET_VAL(1'b0)) u_p2 (
        .s(if_p2.s), .r(if_p2.r), .clk(clk), .reset(reset),
        .q(if_p2.q), .qn(if_p2.qn), .invalid(if_p2.invalid));
    srff #(.WIDTH(1), .BOTH_POLICY(SR_TOGGLE), .RESET_VAL(1'b0)) u_p3 (
        .s(if_p3.s), .r(if_p3.r), .clk(clk), .reset(reset),
        .q(if_p3.q), .qn(if_p3.qn), .invalid(if_p3.invalid));
    srff #(.WIDTH(4), .BOTH_POLICY(SR_HOLD), .RESET_VAL(4'b0000)) u_w4 (
        .s(if_w4.s), .r(if_w4.r), .clk(clk), .reset(reset),
        .q(if_w4.q), .qn(if_w4.qn), .invalid(if_w4.invalid));

    logic [3:0] q_all, qn_all, inv_all;
    assign q_all   = {if_p3.q, if_p2.q, if_p1.q, if_p0.q};
    assign qn_all  = {if_p3.qn, if_p2.qn, if_p1.qn, if_p0.qn};
    assign inv_all = {if_p3.invalid, if_p2.invalid, if_p1.invalid, if_p0.invalid};

    // qp holds the expected q of the 1-bit banks, one bit per policy {tog, clr, set, hold}
    typedef struct {
        logic       s;
        logic       r;
        logic [3:0] qp;
        logic       inv;
        logic [3:0] s4;
        logic [3:0] r4;
        logic [3:0] q4;
        logic [3:0] inv4;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic s1, input logic r1, input logic [3:0] s4, input logic [3:0] r4);
        if_p0.s = s1; if_p0.r = r1;
        if_p1.s = s1; if_p1.r = r1;
        if_p2.s = s1; if_p2.r = r1;
        if_p3.s = s1; if_p3.r = r1;
        if_w4.s = s4; if_w4.r = r4;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] qp, input logic inv,
                           input logic [3:0] q4, input logic [3:0] inv4);
        chk({tag, " q"},     q_all,      qp);
        chk({tag, " qn"},    qn_all,     ~qp);
        chk({tag, " inv"},   inv_all,    {4{inv}});
        chk({tag, " q4"},    if_w4.q,    q4);
        chk({tag, " qn4"},   if_w4.qn,   ~q4);
        chk({tag, " inv4"},  if_w4.invalid, inv4);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0101, 4'b0011, 4'b0100, 4'b0001};
        tbl[1]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 4'b0011, 1'b1, 4'b1010, 4'b1100, 4'b1011, 4'b1000};
        tbl[3]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b1011, 4'b0000};
        tbl[4]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 1'b1, 4'b0011, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
        tbl[7]  = '{1'b1, 1'b1, 4'b1011, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b1, 1'b1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{1'b1, 1'b1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        reset = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        #20;
        chk_all("reset", 4'b0000, 1'b0, 4'b0000, 4'b0000);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].s, tbl[i].r, tbl[i].s4, tbl[i].r4);
            @(posedge clk);
            #10;
            chk_all($sformatf("row%0d", i), tbl[i].qp, tbl[i].inv, tbl[i].q4, tbl[i].inv4);
            @(negedge clk);
        end

        // async reset between edges overrides a pending set and holds across edges
        drive(1'b1, 1'b0, 4'b1111, 4'b0000);
        @(posedge clk);
        #10;
        chk_all("preset", 4'b1111, 1'b0, 4'b1111, 4'b0000);
        @(negedge clk);
        #20;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #10;
            chk_all($sformatf("rst_hold%0d", k), 4'b0000, 1'b0, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("rst_release", 4'b0000, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk);
        #10;
        chk_all("post_rst", 4'b1111, 1'b0, 4'b1111, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srff.md
Name: srff

Overview:
- Clocked set/reset flip-flop bank: WIDTH independent SR storage bits updated on the rising edge of clk.
- General-purpose control-flag latch, e.g. sticky status bits set by one event and cleared by another.
- Provides true and complemented outputs plus a per-bit flag that reports the S=R=1 condition.
- Single clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, 1, number of independent SR bits; legal range 1..64.
- BOTH_POLICY, 0, action on a bit when s=1 and r=1 at a clock edge: 0 = hold, 1 = set wins, 2 = reset wins, 3 = toggle.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by reset.

Ports:
- s, input, WIDTH, per-bit synchronous set request.
- r, input, WIDTH, per-bit synchronous reset (clear) request.
- clk, input, 1, clock; rising-edge active.
- reset, input, 1, asynchronous active-high reset.
- q, output, WIDTH, registered state.
- qn, output, WIDTH, combinational complement of q (~q); no extra register.
- invalid, output, WIDTH, registered flag; bit i is 1 for the cycle after an edge that sampled s[i]=r[i]=1.
- Port order is fixed exactly as listed: s, r, clk, reset, q, qn, invalid.
  - Positional instantiations may connect only the first five ports; qn and invalid may be left unconnected.

Behaviour:
- Reset
  - While reset=1: q=RESET_VAL, invalid=0, qn=~RESET_VAL.
  - These values take effect immediately on reset assertion, independent of clk, and hold while reset stays high.
  - Reset dominates s and r.
  - Reset asserted mid-operation discards the pending edge's update.
  - After reset deasserts, the first rising clk edge evaluates s/r normally.
- Per-bit update at each rising clk edge (reset=0):
  - s=0, r=0: q holds.
  - s=1, r=0: q=1.
  - s=0, r=1: q=0.
  - s=1, r=1: action set by BOTH_POLICY (hold / 1 / 0 / ~q). invalid bit goes to 1.
- invalid bit returns to 0 at the next edge where s and r are not both 1.
- Latency: one edge from sampled s/r to q and invalid. qn follows q combinationally, with no additional cycle.
- Bits are fully independent; no cross-bit interaction.
- No X is ever driven on q, including for S=R=1.
- s and r are sampled only at rising edges. Glitches between edges have no effect.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Decomposition:
- Shared package srff_pkg:
  - Localparams for the BOTH_POLICY encodings: SR_HOLD=0, SR_SET=1, SR_CLR=2, SR_TOGGLE=3.
  - Function sr_next(s, r, q, policy) returning the next-state bit.
- One natural sub-module: srff_bit, a single-bit cell instantiated WIDTH times in a generate loop.
  - srff_bit contains the async-reset register for q and the invalid flag.
  - The top level drives qn and distributes RESET_VAL bits.

Test Plan (WIDTH=1, BOTH_POLICY=0, RESET_VAL=0, clk period 100 ns, first rising edge at 50 ns, stimulus changed at 100 ns steps on falling edges):
- Power-up with s=0, r=0, reset=0: q, invalid and qn take the values the implementation assigns at time zero. Pulse reset to establish q=0 and qn=1 before checking.
- s=1, r=0 at 100 ns -> q=1 and qn=0 after the 150 ns edge. Then s=0, r=0 at 200 ns -> q stays 1 at 250 ns.
- s=1, r=1 at 300 ns -> at 350 ns q holds 1 and invalid=1. s=0, r=0 at 400 ns -> invalid=0 at 450 ns, q=1.
- Starting with q=1, s=0, r=1 -> q=0 at the next edge.
- Repeat the S=R=1 step for each policy:
  - Policy 1: q=1.
  - Policy 2: q=0.
  - Policy 3: q toggles on every edge while both inputs are held.
- s=1, r=0, reset=1 asserted at 700 ns, between edges -> q=0 immediately, before the 750 ns edge. q stays 0 through further edges while reset=1. After reset drops, q=1 at the next edge.
- WIDTH=4, s=4'b0101, r=4'b0011 from q=4'b0000 -> after one edge: q=4'b0100 (bit0 held under policy 0), invalid=4'b0001.
